// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared state encoding for the data-memory access controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } mem_state_t;

    localparam int c_default_block_words = 4;

    function automatic int unsigned idx_width(input int unsigned words);
        return $clog2(words);
    endfunction

endpackage : mem_ctrl_pkg

`default_nettype wire

// File: rtl/refill_counter.sv
// ============================================================================
// Module      : refill_counter
// Description : Word index within a cache line being refilled; wraps at MAX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module refill_counter #(
    parameter int WIDTH = 2,
    parameter int MAX   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] r_count;

    // MAX is 2^WIDTH-1, so the natural overflow of +1 performs the wrap to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign wrap  = (r_count == WIDTH'(MAX));

endmodule : refill_counter

`default_nettype wire

// File: rtl/mem_access_controller.sv
// ============================================================================
// Module      : mem_access_controller
// Description : Stalls the single-cycle core across data-cache refills and
//               write-through stores. Optional MEM_PERF_CNT_EN adds hit/miss
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int BLOCK_WORDS = c_default_block_words,
    parameter int IDX_W       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             cache_hit,
    input  logic             mem_ready,
    output logic             stall,
    output logic             mem_rd_req,
    output logic             mem_wr_req,
    output logic             refill_we,
    output logic [IDX_W-1:0] refill_idx,
    output logic             cache_wr_en
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);

    localparam int c_last_idx = BLOCK_WORDS - 1;

    mem_state_t       r_state;
    mem_state_t       w_next;
    logic             w_stall;
    logic             w_rd_req;
    logic             w_wr_req;
    logic             w_refill_we;
    logic             w_cache_wr_en;
    logic             w_idx_clear;
    logic             w_idx_inc;
    logic             w_idx_last;
    logic [IDX_W-1:0] w_idx;

    refill_counter #(
        .WIDTH (IDX_W),
        .MAX   (c_last_idx)
    ) u_refill_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_idx_inc),
        .clear (w_idx_clear),
        .count (w_idx),
        .wrap  (w_idx_last)
    );

    // Mealy decode: a store wins over a load if the decoder ever asserts both.
    always_comb begin
        w_stall       = 1'b0;
        w_rd_req      = 1'b0;
        w_wr_req      = 1'b0;
        w_refill_we   = 1'b0;
        w_cache_wr_en = 1'b0;
        w_idx_clear   = 1'b0;
        w_idx_inc     = 1'b0;
        w_next        = r_state;
        case (r_state)
            IDLE: begin
                if (mem_write) begin
                    w_stall       = 1'b1;
                    w_wr_req      = 1'b1;
                    w_cache_wr_en = cache_hit;
                    w_next        = WRITE;
                end else if (mem_read && !cache_hit) begin
                    w_stall     = 1'b1;
                    w_rd_req    = 1'b1;
                    w_idx_clear = 1'b1;
                    w_next      = REFILL;
                end
            end
            REFILL: begin
                w_stall  = 1'b1;
                w_rd_req = 1'b1;
                if (mem_ready) begin
                    w_refill_we = 1'b1;
                    w_idx_inc   = 1'b1;
                    if (w_idx_last) begin
                        w_next = RELEASE;
                    end
                end
            end
            WRITE: begin
                w_stall  = 1'b1;
                w_wr_req = 1'b1;
                if (mem_ready) begin
                    w_next = RELEASE;
                end
            end
            RELEASE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are combinational from inputs, so force them low during reset.
    assign stall       = rst_n & w_stall;
    assign mem_rd_req  = rst_n & w_rd_req;
    assign mem_wr_req  = rst_n & w_wr_req;
    assign refill_we   = rst_n & w_refill_we;
    assign cache_wr_en = rst_n & w_cache_wr_en;
    assign refill_idx  = w_idx;

`ifdef MEM_PERF_CNT_EN
    logic        w_hit_evt;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    assign w_hit_evt = (r_state == IDLE) && !mem_write && mem_read && cache_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_evt) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_idx_clear) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule : mem_access_controller

`default_nettype wire

// File: tb/tb_mem_access_controller.sv
// ============================================================================
// Module      : tb_mem_access_controller
// Description : Directed self-checking bench for mem_access_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_controller;

    logic       clk;
    logic       rst_n;
    logic       mem_read;
    logic       mem_write;
    logic       cache_hit;
    logic       mem_ready;
    logic       stall;
    logic       mem_rd_req;
    logic       mem_wr_req;
    logic       refill_we;
    logic [1:0] refill_idx;
    logic       cache_wr_en;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_controller #(
        .BLOCK_WORDS (4),
        .IDX_W       (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .cache_hit   (cache_hit),
        .mem_ready   (mem_ready),
        .stall       (stall),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .refill_we   (refill_we),
        .refill_idx  (refill_idx),
        .cache_wr_en (cache_wr_en)
`ifdef MEM_PERF_CNT_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {stall, mem_rd_req, mem_wr_req, refill_we, refill_idx[1:0], cache_wr_en}
    function automatic logic [6:0] outs();
        return {stall, mem_rd_req, mem_wr_req, refill_we, refill_idx, cache_wr_en};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs at the falling edge, advance.
    task automatic step(input string tag, input logic rd, input logic wr, input logic hit,
                        input logic rdy, input logic [6:0] exp);
        mem_read  = rd;
        mem_write = wr;
        cache_hit = hit;
        mem_ready = rdy;
        @(negedge clk);
        chk(tag, {25'd0, outs()}, {25'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic miss_seq(input string tag);
        step({tag, "_idle"}, 1, 0, 0, 1, 7'b1100_00_0);
        step({tag, "_r0"},   1, 0, 0, 1, 7'b1101_00_0);
        step({tag, "_r1"},   1, 0, 0, 1, 7'b1101_01_0);
        step({tag, "_r2"},   1, 0, 0, 1, 7'b1101_10_0);
        step({tag, "_r3"},   1, 0, 0, 1, 7'b1101_11_0);
        step({tag, "_rel"},  1, 0, 0, 1, 7'b0000_00_0);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        cache_hit = 1'b1;
        mem_ready = 1'b1;
        #2;
        chk("reset_outs", {25'd0, outs()}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_hold", {25'd0, outs()}, 32'd0);
        rst_n = 1'b1;

        // Load hit: no stall, stays IDLE
        step("hit",       1, 0, 1, 0, 7'b0000_00_0);
        step("hit_again", 1, 0, 1, 1, 7'b0000_00_0);
        step("idle",      0, 0, 0, 1, 7'b0000_00_0);

        // Load miss with mem_ready always high; RELEASE ignores inputs
        miss_seq("miss");
        step("miss_after", 0, 0, 0, 0, 7'b0000_00_0);

        // Load miss with a mem_ready gap on the second refill cycle
        step("gap_idle", 1, 0, 0, 0, 7'b1100_00_0);
        step("gap_r0",   1, 0, 0, 1, 7'b1101_00_0);
        step("gap_wait", 1, 0, 0, 0, 7'b1100_01_0);
        step("gap_r1",   1, 0, 0, 1, 7'b1101_01_0);
        step("gap_r2",   1, 0, 0, 1, 7'b1101_10_0);
        step("gap_r3",   1, 0, 0, 1, 7'b1101_11_0);
        step("gap_rel",  1, 0, 0, 0, 7'b0000_00_0);

        // Store hit, mem_ready arrives on the third WRITE cycle
        step("st_idle",  0, 1, 1, 1, 7'b1010_00_1);
        step("st_w0",    0, 1, 1, 0, 7'b1010_00_0);
        step("st_w1",    0, 1, 1, 0, 7'b1010_00_0);
        step("st_w2",    0, 1, 1, 1, 7'b1010_00_0);
        step("st_rel",   0, 1, 1, 0, 7'b0000_00_0);
        step("st_after", 0, 0, 0, 0, 7'b0000_00_0);

        // Store miss with mem_read also set: treated as store, no cache write
        step("stm_idle", 1, 1, 0, 0, 7'b1010_00_0);
        step("stm_w0",   1, 1, 0, 1, 7'b1010_00_0);
        step("stm_rel",  1, 1, 0, 1, 7'b0000_00_0);

        // Reset asserted mid-refill at idx 2
        step("rst_idle", 1, 0, 0, 1, 7'b1100_00_0);
        step("rst_r0",   1, 0, 0, 1, 7'b1101_00_0);
        step("rst_r1",   1, 0, 0, 1, 7'b1101_01_0);
        @(negedge clk);
        chk("rst_r2", {25'd0, outs()}, {25'd0, 7'b1101_10_0});
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_abort", {25'd0, outs()}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("rst_post_hit", 1, 0, 1, 1, 7'b0000_00_0);
        miss_seq("rst_post_miss");

        // Performance counters: fresh reset, then 3 hits and 2 misses
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step("pc_hit0", 1, 0, 1, 0, 7'b0000_00_0);
        miss_seq("pc_miss0");
        step("pc_hit1", 1, 0, 1, 0, 7'b0000_00_0);
        step("pc_hit2", 1, 0, 1, 0, 7'b0000_00_0);
        miss_seq("pc_miss1");
        step("pc_idle", 0, 0, 0, 0, 7'b0000_00_0);
`ifdef MEM_PERF_CNT_EN
        chk("hit_count",  hit_count,  32'd3);
        chk("miss_count", miss_count, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_access_controller

`default_nettype wire
